// File: rtl/prog_loader.sv
// prog_loader: receives a program image as a byte stream and writes it into
// instruction memory while holding the CPU in reset.
//
// Stream: count_hi, count_lo (N words, big-endian, valid range 1..256),
//         4N payload bytes (MSB-first per word), then one checksum byte
//         equal to the XOR of all payload bytes.
//
// Ports
//   CLK          clock, rising edge
//   RESET        synchronous active-high reset
//   start        one-cycle pulse that opens a load session (IDLE or ERR only)
//   rx_data      incoming byte
//   rx_valid     rx_data valid this cycle
//   rx_ready     loader accepts a byte this cycle (transfer = valid & ready)
//   mem_we       byte write strobe, the cycle after each payload transfer
//   mem_addr     byte address of the write (0..1023)
//   mem_wdata    byte to write
//   cpu_hold     holds the CPU in reset during a session and after an error
//   busy         session in progress
//   done         one-cycle pulse after a good checksum
//   err          set while in the error state, cleared by a new start
//   loaded_words word count of the last accepted header
module prog_loader (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [8:0]  loaded_words
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    PAYLOAD,
    CKSUM,
    DONE,
    ERR
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt_hi_p0;
  logic [7:0]  words_m1_p0;
  logic [9:0]  idx_p0;
  logic [7:0]  acc_p0;

  logic        xfer;
  logic [15:0] hdr_n;
  logic        hdr_ok;
  logic        last_byte;
  logic        open_session;

  assign xfer         = rx_valid && rx_ready;
  assign hdr_n        = {cnt_hi_p0, rx_data};
  assign hdr_ok       = (hdr_n != 16'd0) && (hdr_n <= 16'd256);
  // Last payload byte is byte 3 of word N-1.
  assign last_byte    = (idx_p0[9:2] == words_m1_p0) && (idx_p0[1:0] == 2'b11);
  assign open_session = start && ((state == IDLE) || (state == ERR));

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    busy      = 1'b0;
    cpu_hold  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = HDR_HI;
      end
      HDR_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
        if (xfer) state_nxt = HDR_LO;
      end
      HDR_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
        if (xfer) state_nxt = hdr_ok ? PAYLOAD : ERR;
      end
      PAYLOAD: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
        if (xfer && last_byte) state_nxt = CKSUM;
      end
      CKSUM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
        if (xfer) state_nxt = (rx_data == acc_p0) ? DONE : ERR;
      end
      DONE: begin
        busy      = 1'b1;
        cpu_hold  = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        // CPU stays held so a partially loaded program never runs.
        cpu_hold = 1'b1;
        err      = 1'b1;
        if (start) state_nxt = HDR_HI;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: byte accepted this edge, memory write presented next cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 8'd0;
      loaded_words <= 9'd0;
      cnt_hi_p0    <= 8'd0;
      words_m1_p0  <= 8'd0;
      idx_p0       <= 10'd0;
      acc_p0       <= 8'd0;
    end else begin
      state  <= state_nxt;
      mem_we <= (state == PAYLOAD) && xfer;

      if (open_session) begin
        acc_p0 <= 8'd0;
        idx_p0 <= 10'd0;
      end

      if ((state == HDR_HI) && xfer) cnt_hi_p0 <= rx_data;

      if ((state == HDR_LO) && xfer && hdr_ok) begin
        loaded_words <= hdr_n[8:0];
        words_m1_p0  <= 8'(hdr_n - 16'd1);
        idx_p0       <= 10'd0;
      end

      if ((state == PAYLOAD) && xfer) begin
        mem_addr  <= {22'd0, idx_p0};
        mem_wdata <= rx_data;
        idx_p0    <= idx_p0 + 10'd1;
        acc_p0    <= acc_p0 ^ rx_data;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [8:0]  loaded_words;

  prog_loader dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .loaded_words (loaded_words)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        st;
    logic        vld;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wd;
    logic        hold;
    logic        bsy;
    logic        dn;
    logic        er;
    logic [8:0]  lw;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Expected outputs are those seen just after the edge that samples the inputs.
  task automatic v(input logic rst, input logic st, input logic vld, input logic [7:0] d,
                   input logic rdy, input logic we, input logic [31:0] addr, input logic [7:0] wd,
                   input logic hold, input logic bsy, input logic dn, input logic er,
                   input logic [8:0] lw);
    vec_t r;
    r.rst = rst; r.st = st; r.vld = vld; r.d = d;
    r.rdy = rdy; r.we = we; r.addr = addr; r.wd = wd;
    r.hold = hold; r.bsy = bsy; r.dn = dn; r.er = er; r.lw = lw;
    vecs.push_back(r);
  endtask

  function automatic logic [7:0] pbyte(input int i);
    pbyte = 8'((i * 7 + 3) & 255);
  endfunction

  initial begin
    RESET = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    // ---- good load: 00 01 | 00 01 10 20 | 31
    v(1,0,0,8'h00, 0,0,0,8'h00, 0,0,0,0, 0);
    v(0,1,0,8'h00, 1,0,0,8'h00, 1,1,0,0, 0);
    v(0,0,1,8'h00, 1,0,0,8'h00, 1,1,0,0, 0);
    v(0,0,1,8'h01, 1,0,0,8'h00, 1,1,0,0, 1);
    v(0,0,1,8'h00, 1,1,0,8'h00, 1,1,0,0, 1);
    v(0,0,1,8'h01, 1,1,1,8'h01, 1,1,0,0, 1);
    v(0,0,1,8'h10, 1,1,2,8'h10, 1,1,0,0, 1);
    v(0,0,1,8'h20, 1,1,3,8'h20, 1,1,0,0, 1);
    v(0,0,1,8'h31, 0,0,0,8'h00, 1,1,1,0, 1);
    v(0,0,0,8'h00, 0,0,0,8'h00, 0,0,0,0, 1);
    // ---- header 00 00 -> ERR; bytes ignored while in ERR
    v(0,1,0,8'h00, 1,0,0,8'h00, 1,1,0,0, 1);
    v(0,0,1,8'h00, 1,0,0,8'h00, 1,1,0,0, 1);
    v(0,0,1,8'h00, 0,0,0,8'h00, 1,0,0,1, 1);
    v(0,0,1,8'h55, 0,0,0,8'h00, 1,0,0,1, 1);
    // ---- restart from ERR: AA BB CC DD, checksum 00, with a stall + stray start
    v(0,1,0,8'h00, 1,0,0,8'h00, 1,1,0,0, 1);
    v(0,0,1,8'h00, 1,0,0,8'h00, 1,1,0,0, 1);
    v(0,0,1,8'h01, 1,0,0,8'h00, 1,1,0,0, 1);
    v(0,0,1,8'hAA, 1,1,0,8'hAA, 1,1,0,0, 1);
    v(0,1,0,8'h77, 1,0,0,8'h00, 1,1,0,0, 1);
    v(0,0,1,8'hBB, 1,1,1,8'hBB, 1,1,0,0, 1);
    v(0,0,1,8'hCC, 1,1,2,8'hCC, 1,1,0,0, 1);
    v(0,0,1,8'hDD, 1,1,3,8'hDD, 1,1,0,0, 1);
    v(0,0,0,8'h00, 1,0,0,8'h00, 1,1,0,0, 1);
    v(0,0,1,8'h00, 0,0,0,8'h00, 1,1,1,0, 1);
    v(0,1,0,8'h00, 0,0,0,8'h00, 0,0,0,0, 1);
    // ---- same stream, bad checksum 01 -> ERR, CPU stays held
    v(0,1,0,8'h00, 1,0,0,8'h00, 1,1,0,0, 1);
    v(0,0,1,8'h00, 1,0,0,8'h00, 1,1,0,0, 1);
    v(0,0,1,8'h01, 1,0,0,8'h00, 1,1,0,0, 1);
    v(0,0,1,8'hAA, 1,1,0,8'hAA, 1,1,0,0, 1);
    v(0,0,1,8'hBB, 1,1,1,8'hBB, 1,1,0,0, 1);
    v(0,0,1,8'hCC, 1,1,2,8'hCC, 1,1,0,0, 1);
    v(0,0,1,8'hDD, 1,1,3,8'hDD, 1,1,0,0, 1);
    v(0,0,1,8'h01, 0,0,0,8'h00, 1,0,0,1, 1);
    v(0,0,0,8'h00, 0,0,0,8'h00, 1,0,0,1, 1);
    // ---- reset after 3rd payload byte: no write of 4th byte
    v(0,1,0,8'h00, 1,0,0,8'h00, 1,1,0,0, 1);
    v(0,0,1,8'h00, 1,0,0,8'h00, 1,1,0,0, 1);
    v(0,0,1,8'h01, 1,0,0,8'h00, 1,1,0,0, 1);
    v(0,0,1,8'h11, 1,1,0,8'h11, 1,1,0,0, 1);
    v(0,0,1,8'h22, 1,1,1,8'h22, 1,1,0,0, 1);
    v(0,0,1,8'h33, 1,1,2,8'h33, 1,1,0,0, 1);
    v(1,1,1,8'h44, 0,0,0,8'h00, 0,0,0,0, 0);
    v(0,0,1,8'h44, 0,0,0,8'h00, 0,0,0,0, 0);
    // ---- header 01 01 (257) -> ERR
    v(0,1,0,8'h00, 1,0,0,8'h00, 1,1,0,0, 0);
    v(0,0,1,8'h01, 1,0,0,8'h00, 1,1,0,0, 0);
    v(0,0,1,8'h01, 0,0,0,8'h00, 1,0,0,1, 0);
    v(1,0,0,8'h00, 0,0,0,8'h00, 0,0,0,0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      logic ok;
      @(negedge CLK);
      RESET = vecs[i].rst; start = vecs[i].st;
      rx_valid = vecs[i].vld; rx_data = vecs[i].d;
      @(posedge CLK);
      #1;
      ok = (rx_ready === vecs[i].rdy) && (mem_we === vecs[i].we) &&
           (cpu_hold === vecs[i].hold) && (busy === vecs[i].bsy) &&
           (done === vecs[i].dn) && (err === vecs[i].er) &&
           (loaded_words === vecs[i].lw);
      if (vecs[i].we || vecs[i].rst)
        ok = ok && (mem_addr === vecs[i].addr) && (mem_wdata === vecs[i].wd);
      n_vec++;
      if (!ok) begin
        n_fail++;
        $display("FAIL vec%0d: got rdy=%b we=%b addr=%0h wd=%h hold=%b busy=%b done=%b err=%b lw=%0d ; want rdy=%b we=%b addr=%0h wd=%h hold=%b busy=%b done=%b err=%b lw=%0d",
                 i, rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err, loaded_words,
                 vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].hold, vecs[i].bsy,
                 vecs[i].dn, vecs[i].er, vecs[i].lw);
      end
    end

    // ---- N=256 with randomly toggling rx_valid
    begin
      int          k;
      int          wr_cnt;
      int          done_cnt;
      int          cycles;
      logic [7:0]  cks;
      logic [7:0]  b;
      logic        rdy_s;
      logic        exp_we;

      cks = 8'h00;
      for (int i = 0; i < 1024; i++) cks = cks ^ pbyte(i);

      @(negedge CLK);
      RESET = 1'b0; start = 1'b1; rx_valid = 1'b0;
      @(negedge CLK);
      start = 1'b0;

      k = 0; wr_cnt = 0; done_cnt = 0; cycles = 0;
      while (k < 1027 && cycles < 8000) begin
        if (k == 0)       b = 8'h01;
        else if (k == 1)  b = 8'h00;
        else if (k < 1026) b = pbyte(k - 2);
        else              b = cks;
        rx_valid = 1'($urandom_range(0, 1));
        rx_data  = b;
        rdy_s    = rx_ready;
        @(posedge CLK);
        #1;
        exp_we = rx_valid && rdy_s && (k >= 2) && (k < 1026);
        n_vec++;
        if (rdy_s !== 1'b1 || mem_we !== exp_we ||
            (exp_we && (mem_addr !== 32'(k - 2) || mem_wdata !== b))) begin
          n_fail++;
          $display("FAIL rand k=%0d: got rdy=%b we=%b addr=%0d wd=%h ; want rdy=1 we=%b addr=%0d wd=%h",
                   k, rdy_s, mem_we, mem_addr, mem_wdata, exp_we, k - 2, b);
        end
        if (mem_we) wr_cnt++;
        if (done) done_cnt++;
        if (rx_valid && rdy_s) k++;
        cycles++;
        @(negedge CLK);
      end
      rx_valid = 1'b0;
      n_vec++;
      if (k < 1027) begin
        n_fail++;
        $display("FAIL rand_timeout: got %0d bytes sent, want 1027", k);
      end
      for (int c = 0; c < 3; c++) begin
        @(posedge CLK);
        #1;
        if (mem_we) wr_cnt++;
        if (done) done_cnt++;
      end
      n_vec++;
      if (wr_cnt != 1024 || done_cnt != 1 || loaded_words !== 9'd256 || cpu_hold !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_totals: got writes=%0d done=%0d lw=%0d hold=%b ; want writes=1024 done=1 lw=256 hold=0",
                 wr_cnt, done_cnt, loaded_words, cpu_hold);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 CLK  input  1  single clock; all state changes on rising edge.
REQ-002 RESET  input  1  synchronous, active-high reset.
REQ-003 start  input  1  single-cycle pulse that opens a load session.
REQ-004 rx_data  input  8  incoming program byte stream.
REQ-005 rx_valid  input  1  rx_data valid this cycle.
REQ-006 rx_ready  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid and rx_ready are both 1 at a rising edge.
REQ-007 mem_we  output  1  byte-write strobe to instruction memory, one cycle per byte.
REQ-008 mem_addr  output  32  byte address of the write.
REQ-009 mem_wdata  output  8  byte to write.
REQ-010 cpu_hold  output  1  holds the processor PC in reset while 1.
REQ-011 busy  output  1  session in progress.
REQ-012 done  output  1  one-cycle pulse on successful load.
REQ-013 err  output  1  sticky error flag.
REQ-014 loaded_words  output  9  word count N of the last accepted header.

Function
REQ-015 Stream format SHALL be: count_hi, count_lo (N, big-endian), then 4N payload bytes, then 1 checksum byte equal to the XOR of all payload bytes.
REQ-016 States SHALL be IDLE, HDR_HI, HDR_LO, PAYLOAD, CKSUM, DONE, ERR.
REQ-017 IDLE: rx_ready=0; start=1 -> HDR_HI next cycle, cpu_hold=1, busy=1, err cleared.
REQ-018 rx_ready SHALL be 1 exactly in HDR_HI, HDR_LO, PAYLOAD and CKSUM; 0 elsewhere.
REQ-019 In HDR_HI/HDR_LO, a transfer latches the count byte; after HDR_LO, N in 1..256 -> PAYLOAD with byte index cleared, loaded_words=N; N=0 or N>256 -> ERR, with no memory writes.
REQ-020 In PAYLOAD, each transfer of byte i (0..4N-1) SHALL produce, on the next cycle, mem_we=1, mem_addr=i, mem_wdata=byte, and the XOR accumulator updated. Bytes arrive MSB-first per word, so mem_addr 4k holds instruction bits [31:24].
REQ-021 mem_we SHALL be 0 on every cycle not following a PAYLOAD transfer; back-to-back transfers SHALL give back-to-back writes with no stall.
REQ-022 After the transfer of byte 4N-1, the state SHALL go to CKSUM; rx_valid=0 cycles SHALL hold the state and the index.
REQ-023 CKSUM transfer: match -> DONE; mismatch -> ERR.
REQ-024 DONE SHALL last exactly one cycle with done=1, then IDLE, busy=0, cpu_hold=0.
REQ-025 ERR: err=1, busy=0, cpu_hold stays 1 (no corrupt program runs), rx_ready=0; exit only via start (-> HDR_HI, err cleared) or RESET.
REQ-026 start SHALL be ignored in HDR_HI, HDR_LO, PAYLOAD, CKSUM and DONE.
REQ-027 Byte index SHALL be 10 bits; the largest address written is 1023, so no wrap-around occurs.

Reset
REQ-028 RESET=1 SHALL force, on the next edge: state IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, err=0, loaded_words=0, accumulator=0, index=0. RESET takes priority over start and over transfers.
REQ-029 RESET during a session SHALL abort the session immediately; bytes already written stay in memory and no further writes occur.

Verification
REQ-030 Bench SHALL cover: start; stream 00 01 00 01 10 20 31 = 00^01^10^20 -> writes addr0..3 = 00,01,10,20 on consecutive cycles; done pulse; cpu_hold 1->0; loaded_words=1.
REQ-031 Bench SHALL cover: header 00 00 -> ERR, err=1, no mem_we, cpu_hold=1; then start and a valid stream -> err clears and done pulses.
REQ-032 Bench SHALL cover: N=1, payload AA BB CC DD, checksum 00 (expected 00) -> done; same stream with checksum 01 -> err=1, cpu_hold stays 1.
REQ-033 Bench SHALL cover: N=256 with rx_valid toggling randomly -> 1024 writes at addr 0..1023 in order, none duplicated; done pulses once.
REQ-034 Bench SHALL cover: RESET asserted after the 3rd payload byte -> next cycle all outputs at reset values, no write for the 4th byte; header 01 01 (257) -> ERR.
